// File: rtl/y86_writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, 15-entry register file, run/halt status and retire counter.
// Optional WB_READ_BYPASS_EN: read ports return the value being committed this cycle on an address match.
module y86_writeback_regfile #(
  parameter int unsigned        DATA_W    = 64,
  parameter int unsigned        CNT_W     = 32,
  parameter logic [DATA_W-1:0]  RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              W_stall,
  input  logic              W_bubble,
  input  logic [3:0]        m_icode,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        M_destE,
  input  logic [3:0]        M_destM,
  input  logic [1:0]        m_stat,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] rd_valA,
  output logic [DATA_W-1:0] rd_valB,
  output logic [3:0]        W_icode,
  output logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] W_valM,
  output logic [3:0]        W_destE,
  output logic [3:0]        W_destM,
  output logic [1:0]        W_stat,
  output logic [1:0]        cpu_stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int unsigned REG_N    = 15;
  localparam int unsigned RSP_IDX  = 4;
  localparam logic [3:0]  REG_NONE = 4'hF;
  localparam logic [3:0]  I_NOP    = 4'h1;
  localparam logic [1:0]  STAT_AOK = 2'd0;

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_e;

  state_e state_q, state_d;

  logic [3:0]        W_icode_q, W_icode_d;
  logic [DATA_W-1:0] W_valE_q,  W_valE_d;
  logic [DATA_W-1:0] W_valM_q,  W_valM_d;
  logic [3:0]        W_destE_q, W_destE_d;
  logic [3:0]        W_destM_q, W_destM_d;
  logic [1:0]        W_stat_q,  W_stat_d;
  logic [1:0]        cpu_stat_q, cpu_stat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  logic [DATA_W-1:0] rf_d [REG_N];

  logic commit_en;
  logic cnt_en;
  logic halted_st;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // Next-state: any non-AOK status reaching W stops the machine until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (W_stat_q != STAT_AOK) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  // State-decoded controls
  always_comb begin
    commit_en = 1'b0;
    cnt_en    = 1'b0;
    halted_st = 1'b0;
    case (state_q)
      S_RUN: begin
        commit_en = (W_stat_q == STAT_AOK);
        cnt_en    = (W_stat_q == STAT_AOK) && (W_icode_q != I_NOP);
      end
      S_HALTED: halted_st = 1'b1;
      default: ;
    endcase
  end

  // W register next value: halted > stall > bubble > load
  always_comb begin
    W_icode_d = W_icode_q;
    W_valE_d  = W_valE_q;
    W_valM_d  = W_valM_q;
    W_destE_d = W_destE_q;
    W_destM_d = W_destM_q;
    W_stat_d  = W_stat_q;
    if (!halted_st && !W_stall) begin
      if (W_bubble) begin
        W_icode_d = I_NOP;
        W_valE_d  = '0;
        W_valM_d  = '0;
        W_destE_d = REG_NONE;
        W_destM_d = REG_NONE;
        W_stat_d  = STAT_AOK;
      end else begin
        W_icode_d = m_icode;
        W_valE_d  = m_valE;
        W_valM_d  = m_valM;
        W_destE_d = M_destE;
        W_destM_d = M_destM;
        W_stat_d  = m_stat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      W_icode_q <= I_NOP;
      W_valE_q  <= '0;
      W_valM_q  <= '0;
      W_destE_q <= REG_NONE;
      W_destM_q <= REG_NONE;
      W_stat_q  <= STAT_AOK;
    end else begin
      W_icode_q <= W_icode_d;
      W_valE_q  <= W_valE_d;
      W_valM_q  <= W_valM_d;
      W_destE_q <= W_destE_d;
      W_destM_q <= W_destM_d;
      W_stat_q  <= W_stat_d;
    end
  end

  // Commit: valM written last so it wins when both dests match (popq %rsp)
  always_comb begin
    rf_d = rf_q;
    if (commit_en) begin
      for (int i = 0; i < REG_N; i++) begin
        if (W_destE_q == 4'(i)) rf_d[i] = W_valE_q;
        if (W_destM_q == 4'(i)) rf_d[i] = W_valM_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++)
        rf_q[i] <= (i == RSP_IDX) ? RSP_RESET : '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Architectural status and saturating retire counter
  always_comb begin
    cpu_stat_d = cpu_stat_q;
    if (state_q == S_RUN && W_stat_q != STAT_AOK) cpu_stat_d = W_stat_q;
    cnt_d = cnt_q;
    if (cnt_en && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_stat_q <= STAT_AOK;
      cnt_q      <= '0;
    end else begin
      cpu_stat_q <= cpu_stat_d;
      cnt_q      <= cnt_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    if (addr != REG_NONE) begin
      v = rf_q[addr];
`ifdef WB_READ_BYPASS_EN
      if (commit_en && W_destE_q == addr) v = W_valE_q;
      if (commit_en && W_destM_q == addr) v = W_valM_q;
`endif
    end
    return v;
  endfunction

  assign rd_valA    = read_port(d_srcA);
  assign rd_valB    = read_port(d_srcB);
  assign W_icode    = W_icode_q;
  assign W_valE     = W_valE_q;
  assign W_valM     = W_valM_q;
  assign W_destE    = W_destE_q;
  assign W_destM    = W_destM_q;
  assign W_stat     = W_stat_q;
  assign cpu_stat   = cpu_stat_q;
  assign halted     = halted_st;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Scoreboard bench for y86_writeback_regfile: stimulus queues expected values, a negedge monitor checks them.
module tb_y86_writeback_regfile;

  localparam int unsigned DW  = 64;
  localparam int unsigned CW  = 4;
  localparam logic [63:0] RSP = 64'h0000_0000_0000_F000;

  logic          clk = 1'b0;
  logic          rst;
  logic          W_stall, W_bubble;
  logic [3:0]    m_icode, M_destE, M_destM, d_srcA, d_srcB;
  logic [DW-1:0] m_valE, m_valM, rd_valA, rd_valB, W_valE, W_valM;
  logic [1:0]    m_stat, W_stat, cpu_stat;
  logic [3:0]    W_icode, W_destE, W_destM;
  logic          halted;
  logic [CW-1:0] retire_cnt;
  logic          done = 1'b0;

  y86_writeback_regfile #(.DATA_W(DW), .CNT_W(CW), .RSP_RESET(RSP)) dut (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
    .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
    .M_destE(M_destE), .M_destM(M_destM), .m_stat(m_stat),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .rd_valA(rd_valA), .rd_valB(rd_valB),
    .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_destE(W_destE), .W_destM(W_destM), .W_stat(W_stat),
    .cpu_stat(cpu_stat), .halted(halted), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {
    RDA, RDB, WICODE, WVALE, WVALM, WDESTE, WDESTM, WSTAT, CSTAT, HALT, RCNT
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] actual(input sig_e s);
    case (s)
      RDA:    return rd_valA;
      RDB:    return rd_valB;
      WICODE: return 64'(W_icode);
      WVALE:  return W_valE;
      WVALM:  return W_valM;
      WDESTE: return 64'(W_destE);
      WDESTM: return 64'(W_destM);
      WSTAT:  return 64'(W_stat);
      CSTAT:  return 64'(cpu_stat);
      HALT:   return 64'(halted);
      RCNT:   return 64'(retire_cnt);
      default: return 64'hDEAD;
    endcase
  endfunction

  // Monitor: every queued expectation is compared at the next sample point
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [63:0] a;
      c = sb.pop_front();
      a = actual(c.sig);
      total++;
      if (a !== c.exp) begin
        bad++;
        $display("FAIL %s: got %0h expected %0h", c.name, a, c.exp);
      end
    end
  end

  // Watchdog: the stimulus must finish within a bounded time
  initial begin
    #20000;
    if (!done) begin
      bad++;
      $display("FAIL timeout: stimulus did not complete");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic exp_push(input sig_e s, input logic [63:0] v, input string n);
    chk_t c;
    c.sig = s; c.exp = v; c.name = n;
    sb.push_back(c);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_m(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm, input logic [1:0] st);
    m_icode = ic; m_valE = ve; m_valM = vm; M_destE = de; M_destM = dm; m_stat = st;
  endtask

  task automatic idle_m();
    set_m(4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 2'd0);
  endtask

  initial begin
    rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
    d_srcA = 4'hF; d_srcB = 4'hF;
    idle_m();
    step();
    step();
    rst = 1'b0;

    total++;
    if (retire_cnt !== '0 || halted !== 1'b0 || cpu_stat !== 2'd0 || W_icode !== 4'h1) begin
      bad++;
      $display("FAIL reset_state: cnt=%0h halted=%0b cpu_stat=%0h W_icode=%0h",
               retire_cnt, halted, cpu_stat, W_icode);
    end

    // Reset contents
    exp_push(RCNT, 64'd0, "rst_cnt");
    exp_push(HALT, 64'd0, "rst_halted");
    exp_push(CSTAT, 64'd0, "rst_cpu_stat");
    exp_push(WICODE, 64'd1, "rst_W_icode");
    exp_push(WDESTE, 64'hF, "rst_W_destE");
    for (int i = 0; i < 15; i++) begin
      d_srcA = 4'(i);
      d_srcB = 4'(14 - i);
      exp_push(RDA, (i == 4) ? RSP : 64'd0, "rst_regA");
      exp_push(RDB, (i == 10) ? RSP : 64'd0, "rst_regB");
      step();
    end
    d_srcA = 4'hF; d_srcB = 4'hF;
    exp_push(RDA, 64'd0, "read_F");
    step();

    // irmovq-style E write
    set_m(4'h3, 64'd42, 64'd0, 4'h2, 4'hF, 2'd0);
    exp_push(WICODE, 64'd3, "load_W_icode");
    exp_push(WVALE, 64'd42, "load_W_valE");
    exp_push(WDESTE, 64'd2, "load_W_destE");
    exp_push(RCNT, 64'd0, "cnt_before_commit");
    step();
    idle_m(); d_srcA = 4'h2;
    exp_push(RDA, 64'd42, "reg2_42");
    exp_push(RCNT, 64'd1, "cnt_1");
    step();

    // popq %rsp: valM wins
    set_m(4'hB, 64'd8, 64'd99, 4'h4, 4'h4, 2'd0);
    exp_push(WDESTM, 64'd4, "pop_W_destM");
    exp_push(WVALM, 64'd99, "pop_W_valM");
    step();
    idle_m(); d_srcA = 4'h4;
    exp_push(RDA, 64'd99, "pop_rsp_valM_wins");
    exp_push(RCNT, 64'd2, "cnt_2");
    step();
    set_m(4'hB, 64'd8, 64'd99, 4'h4, 4'h3, 2'd0);
    step();
    idle_m(); d_srcA = 4'h4; d_srcB = 4'h3;
    exp_push(RDA, 64'd8, "pop_reg4_valE");
    exp_push(RDB, 64'd99, "pop_reg3_valM");
    exp_push(RCNT, 64'd3, "cnt_3");
    step();

    // Halt on HLT status
    set_m(4'h0, 64'd0, 64'd0, 4'hF, 4'hF, 2'd1);
    exp_push(WSTAT, 64'd1, "halt_W_stat");
    step();
    set_m(4'h3, 64'd555, 64'd0, 4'h5, 4'hF, 2'd0);
    exp_push(HALT, 64'd1, "halted_set");
    exp_push(CSTAT, 64'd1, "cpu_stat_hlt");
    exp_push(RCNT, 64'd3, "cnt_halt_not_counted");
    step();
    set_m(4'h3, 64'd666, 64'd0, 4'h5, 4'hF, 2'd0); d_srcA = 4'h5;
    exp_push(RDA, 64'd0, "halted_no_write");
    exp_push(WVALE, 64'd555, "halted_W_frozen");
    exp_push(RCNT, 64'd3, "halted_cnt_frozen");
    step();
    exp_push(RDA, 64'd0, "halted_no_write2");
    exp_push(HALT, 64'd1, "halted_stays");
    step();
    rst = 1'b1; idle_m(); d_srcA = 4'h2;
    exp_push(HALT, 64'd0, "rst_clears_halted");
    exp_push(CSTAT, 64'd0, "rst_clears_cpu_stat");
    exp_push(RCNT, 64'd0, "rst_clears_cnt");
    exp_push(RDA, 64'd0, "rst_clears_reg2");
    exp_push(WICODE, 64'd1, "rst_W_bubble");
    step();
    rst = 1'b0;

    // Stall / bubble
    set_m(4'h2, 64'd77, 64'd0, 4'h7, 4'hF, 2'd0);
    exp_push(WVALE, 64'd77, "pre_stall_load");
    step();
    W_stall = 1'b1;
    set_m(4'h3, 64'd1234, 64'd0, 4'h8, 4'hF, 2'd0);
    exp_push(WICODE, 64'd2, "stall_W_icode");
    exp_push(WVALE, 64'd77, "stall_W_valE");
    exp_push(WDESTE, 64'd7, "stall_W_destE");
    exp_push(RCNT, 64'd1, "stall_cnt");
    step();
    W_stall = 1'b0; W_bubble = 1'b1; d_srcA = 4'h7;
    exp_push(WICODE, 64'd1, "bubble_W_icode");
    exp_push(WDESTE, 64'hF, "bubble_W_destE");
    exp_push(WDESTM, 64'hF, "bubble_W_destM");
    exp_push(RDA, 64'd77, "reg7_77");
    exp_push(RCNT, 64'd2, "recommit_cnt");
    step();
    W_bubble = 1'b0;
    exp_push(WICODE, 64'd3, "load_after_bubble");
    exp_push(RCNT, 64'd2, "bubble_not_counted");
    step();
    W_stall = 1'b1; W_bubble = 1'b1;
    set_m(4'h5, 64'd321, 64'd0, 4'h9, 4'hF, 2'd0);
    exp_push(WICODE, 64'd3, "stall_bubble_hold_icode");
    exp_push(WVALE, 64'd1234, "stall_bubble_hold_valE");
    exp_push(RCNT, 64'd3, "cnt_3b");
    step();
    W_stall = 1'b0; W_bubble = 1'b0; idle_m(); d_srcB = 4'h8;
    exp_push(RDB, 64'd1234, "reg8_1234");
    exp_push(WICODE, 64'd1, "idle_load");
    exp_push(RCNT, 64'd4, "cnt_4");
    step();

    // Same-cycle read of a committing register
    set_m(4'h3, 64'd7, 64'd0, 4'h6, 4'hF, 2'd0); d_srcB = 4'h6; d_srcA = 4'hF;
`ifdef WB_READ_BYPASS_EN
    exp_push(RDB, 64'd7, "bypass_valE");
`else
    exp_push(RDB, 64'd0, "nobypass_old");
`endif
    exp_push(WDESTE, 64'd6, "bypass_W_destE");
    step();
    idle_m();
    exp_push(RDB, 64'd7, "reg6_7");
    step();
    set_m(4'hB, 64'd8, 64'd9, 4'h6, 4'h6, 2'd0);
`ifdef WB_READ_BYPASS_EN
    exp_push(RDB, 64'd9, "bypass_valM_prio");
`else
    exp_push(RDB, 64'd7, "nobypass_old2");
`endif
    step();
    idle_m();
    exp_push(RDB, 64'd9, "reg6_9");
    exp_push(RCNT, 64'd6, "cnt_6");
    step();

    // Counter saturation (4-bit counter in this bench)
    set_m(4'h3, 64'd0, 64'd0, 4'hF, 4'hF, 2'd0);
    for (int i = 0; i < 14; i++) step();
    exp_push(RCNT, 64'd15, "cnt_saturated");
    idle_m();
    step();
    exp_push(RCNT, 64'd15, "cnt_no_wrap");
    step();
    step();

    done = 1'b1;
    if (total == 0 || bad != 0)
      $display("FAIL summary: total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
